// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-phase accumulator CPU: word geometry, opcodes,
// phase numbering and the front-end run/halt state.
package cpu_pkg;

  localparam int unsigned DWIDTH_DEFAULT  = 8;
  localparam int unsigned OPWIDTH_DEFAULT = 3;
  localparam int unsigned AWIDTH_DEFAULT  = 5;
  localparam int unsigned CWIDTH_DEFAULT  = 16;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] ST  = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [2:0] PH_FETCH0 = 3'd0;
  localparam logic [2:0] PH_FETCH1 = 3'd1;
  localparam logic [2:0] PH_FETCH2 = 3'd2;
  localparam logic [2:0] PH_FETCH3 = 3'd3;
  localparam logic [2:0] PH_EXEC4  = 3'd4;
  localparam logic [2:0] PH_EXEC5  = 3'd5;
  localparam logic [2:0] PH_EXEC6  = 3'd6;
  localparam logic [2:0] PH_EXEC7  = 3'd7;

  typedef enum logic {
    StRun,
    StHalted
  } run_state_e;

  function automatic logic is_last_phase(input logic [2:0] ph);
    return ph == PH_EXEC7;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit instruction phase counter; advances when enabled and flags the 7->0 wrap
// in the same cycle so the owner can count completed instructions.
module phase_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] phase,
  output logic       wrap
);

  logic [2:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (en) begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_FETCH0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
  assign wrap  = en && is_last_phase(phase_q);

endmodule

// File: rtl/fetch_sequencer.sv
// CPU front end: phase sequencing, PC and IR, run/halt control, memory address
// mux and a saturating retired-instruction counter.
module fetch_sequencer #(
  parameter int unsigned DWIDTH  = cpu_pkg::DWIDTH_DEFAULT,
  parameter int unsigned OPWIDTH = cpu_pkg::OPWIDTH_DEFAULT,
  parameter int unsigned AWIDTH  = cpu_pkg::AWIDTH_DEFAULT,
  parameter int unsigned CWIDTH  = cpu_pkg::CWIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DWIDTH-1:0]  data_in,
  input  logic               sel,
  input  logic               ld_ir,
  input  logic               inc_pc,
  input  logic               ld_pc,
  input  logic               halt,
  input  logic               run_req,
  output logic [2:0]         phase,
  output logic [OPWIDTH-1:0] opcode,
  output logic [AWIDTH-1:0]  ir_addr,
  output logic [AWIDTH-1:0]  pc,
  output logic [AWIDTH-1:0]  addr,
  output logic               halted,
  output logic [CWIDTH-1:0]  retired
);
  import cpu_pkg::*;

  run_state_e        state_q, state_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [CWIDTH-1:0] retired_q, retired_d;
  logic              running;
  logic              phase_en;
  logic              phase_wrap;

  assign running = (state_q == StRun);

  // Halt entry freezes the phase; the resume edge itself advances it (4->5).
  always_comb begin
    state_d  = state_q;
    phase_en = 1'b0;
    unique case (state_q)
      StRun: begin
        if (halt) begin
          state_d = StHalted;
        end else begin
          phase_en = 1'b1;
        end
      end
      StHalted: begin
        if (run_req) begin
          state_d  = StRun;
          phase_en = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (phase_en),
    .phase (phase),
    .wrap  (phase_wrap)
  );

  // Strobes are still honoured on the halt-entry cycle so PC steps past the HLT.
  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    if (running) begin
      if (ld_ir) begin
        ir_d = data_in;
      end
      if (ld_pc) begin
        pc_d = ir_q[AWIDTH-1:0];
      end else if (inc_pc) begin
        pc_d = pc_q + AWIDTH'(1);
      end
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (phase_wrap && (retired_q != {CWIDTH{1'b1}})) begin
      retired_d = retired_q + CWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      ir_q      <= '0;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign opcode  = ir_q[DWIDTH-1 -: OPWIDTH];
  assign ir_addr = ir_q[AWIDTH-1:0];
  assign pc      = pc_q;
  assign addr    = sel ? pc_q : ir_q[AWIDTH-1:0];
  assign halted  = (state_q == StHalted);
  assign retired = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        sel, ld_ir, inc_pc, ld_pc, halt, run_req;
  logic [2:0]  phase;
  logic [2:0]  opcode;
  logic [4:0]  ir_addr, pc, addr;
  logic        halted;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .sel     (sel),
    .ld_ir   (ld_ir),
    .inc_pc  (inc_pc),
    .ld_pc   (ld_pc),
    .halt    (halt),
    .run_req (run_req),
    .phase   (phase),
    .opcode  (opcode),
    .ir_addr (ir_addr),
    .pc      (pc),
    .addr    (addr),
    .halted  (halted),
    .retired (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_strobes();
    ld_ir   = 1'b0;
    inc_pc  = 1'b0;
    ld_pc   = 1'b0;
    halt    = 1'b0;
    run_req = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    data_in = 8'h00;
    sel     = 1'b0;
    clear_strobes();
    tick();
    rst = 1'b0;
    check_eq("rst_phase", 32'(phase), 0);
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_opcode", 32'(opcode), 0);
    check_eq("rst_ir_addr", 32'(ir_addr), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_retired", 32'(retired), 0);

    // Free run: 16 cycles, no strobes.
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq("run_phase", 32'(phase), 32'((i + 1) % 8));
    end
    check_eq("run_pc", 32'(pc), 0);
    check_eq("run_retired", 32'(retired), 2);

    // IR load of LDA 7 during phases 2 and 3.
    tick(2);
    check_eq("lda_pre_phase", 32'(phase), 2);
    data_in = 8'hA7;
    ld_ir   = 1'b1;
    tick(2);
    ld_ir = 1'b0;
    check_eq("lda_opcode", 32'(opcode), 5);
    check_eq("lda_ir_addr", 32'(ir_addr), 7);
    sel = 1'b0;
    #1 check_eq("addr_ir", 32'(addr), 7);
    sel = 1'b1;
    #1 check_eq("addr_pc", 32'(addr), 0);

    // PC wrap 31 -> 0; phase 4 -> 4 after 32 cycles, 4 more retirements.
    inc_pc = 1'b1;
    tick(31);
    check_eq("pc_31", 32'(pc), 31);
    tick();
    check_eq("pc_wrap", 32'(pc), 0);
    check_eq("pc_wrap_retired", 32'(retired), 6);
    inc_pc = 1'b0;

    // ld_pc wins over inc_pc.
    data_in = 8'h09;
    ld_ir   = 1'b1;
    tick();
    ld_ir  = 1'b0;
    ld_pc  = 1'b1;
    inc_pc = 1'b1;
    tick();
    check_eq("ldpc_prio", 32'(pc), 9);
    check_eq("ldpc_phase", 32'(phase), 6);

    // Set up IR=0, pc=3 at phase 4.
    clear_strobes();
    data_in = 8'h00;
    ld_ir   = 1'b1;
    tick();
    ld_ir = 1'b0;
    ld_pc = 1'b1;
    tick();
    ld_pc  = 1'b0;
    inc_pc = 1'b1;
    tick(3);
    inc_pc = 1'b0;
    tick();
    check_eq("hlt_pre_phase", 32'(phase), 4);
    check_eq("hlt_pre_pc", 32'(pc), 3);
    check_eq("hlt_pre_retired", 32'(retired), 7);

    // Halt entry honours inc_pc.
    halt   = 1'b1;
    inc_pc = 1'b1;
    tick();
    check_eq("hlt_pc", 32'(pc), 4);
    check_eq("hlt_halted", 32'(halted), 1);
    check_eq("hlt_phase", 32'(phase), 4);
    halt = 1'b0;
    tick(10);
    check_eq("hold_pc", 32'(pc), 4);
    check_eq("hold_phase", 32'(phase), 4);
    check_eq("hold_halted", 32'(halted), 1);
    check_eq("hold_retired", 32'(retired), 7);

    // Resume.
    inc_pc  = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check_eq("resume_halted", 32'(halted), 0);
    check_eq("resume_phase", 32'(phase), 5);
    tick(2);
    check_eq("resume_ph7_retired", 32'(retired), 7);
    tick();
    check_eq("resume_phase0", 32'(phase), 0);
    check_eq("resume_retired", 32'(retired), 8);

    // halt and run_req together while running: halt wins.
    halt    = 1'b1;
    run_req = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("both_halted", 32'(halted), 1);
    check_eq("both_phase", 32'(phase), 0);
    tick();
    run_req = 1'b0;
    check_eq("both_resume", 32'(halted), 0);
    check_eq("both_resume_phase", 32'(phase), 1);

    // Reach pc=12, retired=5, halt, then reset while halted.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    inc_pc = 1'b1;
    tick(12);
    inc_pc = 1'b0;
    tick(28);
    data_in = 8'hFF;
    ld_ir   = 1'b1;
    halt    = 1'b1;
    tick();
    clear_strobes();
    check_eq("pre_rst_pc", 32'(pc), 12);
    check_eq("pre_rst_retired", 32'(retired), 5);
    check_eq("pre_rst_halted", 32'(halted), 1);
    check_eq("pre_rst_opcode", 32'(opcode), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("hrst_phase", 32'(phase), 0);
    check_eq("hrst_pc", 32'(pc), 0);
    check_eq("hrst_halted", 32'(halted), 0);
    check_eq("hrst_retired", 32'(retired), 0);
    check_eq("hrst_opcode", 32'(opcode), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
